// File: rtl/rom_stream_reader.sv
// rom_stream_reader: reads a base/len ROM window and streams it out as valid/ready words.
// Ports: clk/rst_n; i_start,i_base_addr,i_len in; o_busy,o_done out; ROM o_rom_addr,o_rom_rd_en,i_rom_data; stream o_data,o_valid,i_ready,o_last.
module rom_stream_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  output logic                  o_rom_rd_en,
  input  logic [WIDTH-1:0]      i_rom_data,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_last
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic [ADDR_WIDTH:0]   len;
  logic [ADDR_WIDTH:0]   len_m1;
  logic [ADDR_WIDTH:0]   issued;
  logic [ADDR_WIDTH:0]   accepted;
  logic                  inflight;

  logic [WIDTH-1:0]      mem0;
  logic [WIDTH-1:0]      mem1;
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            count;

  logic                  pop;
  logic                  push;
  logic                  rd_en;
  logic                  is_last;
  logic [2:0]            credit;

  assign len_m1  = len - (ADDR_WIDTH+1)'(1);
  assign o_valid = (count != 2'd0);
  assign pop     = o_valid & i_ready;
  assign push    = inflight;
  assign is_last = (accepted == len_m1);
  assign o_last  = o_valid & is_last;
  assign o_data  = rd_ptr ? mem1 : mem0;
  assign o_busy  = (state != S_IDLE);
  assign o_done  = (state == S_DONE);

  // Slots that would still be occupied after this cycle's pop,
  // counting the word already on its way back from the ROM.
  assign credit = 3'(count) + 3'(inflight) - 3'(pop);

  assign rd_en = (state == S_RUN)
               && (issued < len)
               && (credit < 3'd2);

  assign o_rom_rd_en = rd_en;
  assign o_rom_addr  = rd_en ? (base + issued[ADDR_WIDTH-1:0])
                             : addr_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      base     <= '0;
      len      <= '0;
      issued   <= '0;
      accepted <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            base     <= i_base_addr;
            len      <= i_len;
            issued   <= '0;
            accepted <= '0;
            state    <= (i_len == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (rd_en) begin
            issued <= issued + (ADDR_WIDTH+1)'(1);
            if (issued == len_m1) begin
              state <= S_DRAIN;
            end
          end
          if (pop) begin
            accepted <= accepted + (ADDR_WIDTH+1)'(1);
          end
        end
        S_DRAIN: begin
          if (pop) begin
            accepted <= accepted + (ADDR_WIDTH+1)'(1);
            if (is_last) begin
              state <= S_DONE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight  <= 1'b0;
      addr_hold <= '0;
    end else begin
      inflight <= rd_en;
      if (rd_en) begin
        addr_hold <= o_rom_addr;
      end
    end
  end

  // 2-entry FIFO; issue credit guarantees it never overflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0   <= '0;
      mem1   <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) begin
          mem1 <= i_rom_data;
        end else begin
          mem0 <= i_rom_data;
        end
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader: directed checks of rom_stream_reader against a ROM model.
// Ports: none; drives the DUT and prints one summary line.
module tb_rom_stream_reader;

  localparam int DEPTH = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] base;
  logic [8:0] len;
  logic       busy;
  logic       done;
  logic [7:0] rom_addr;
  logic       rom_rd_en;
  logic [7:0] rom_data = 8'h00;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       last;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rom_stream_reader #(.ADDR_WIDTH(8), .WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_start(start),
    .i_base_addr(base),
    .i_len(len),
    .o_busy(busy),
    .o_done(done),
    .o_rom_addr(rom_addr),
    .o_rom_rd_en(rom_rd_en),
    .i_rom_data(rom_data),
    .o_data(data),
    .o_valid(valid),
    .i_ready(ready),
    .o_last(last)
  );

  function automatic logic [7:0] rom_f(input logic [7:0] a);
    return (int'(a) < DEPTH) ? (a + 8'h10) : 8'h00;
  endfunction

  always @(posedge clk) begin
    if (rom_rd_en) rom_data <= rom_f(rom_addr);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // mode 0: ready high; 1: random ready with a 10-cycle stall;
  // 2: ready high plus an ignored start pulse mid-transfer.
  task automatic xfer(input logic [7:0] b, input logic [8:0] n,
                      input int mode, input int exp_done);
    int cyc = 1;
    int n_iss = 0;
    int n_pop = 0;
    int first_v = -1;
    int done_cyc = -1;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic popnow;
    logic [7:0] ea;
    start = 1'b1;
    base  = b;
    len   = n;
    ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 200) begin
      if (mode == 1) begin
        ready = (cyc >= 5 && cyc < 15) ? 1'b0 : 1'($urandom_range(0, 1));
      end else begin
        ready = 1'b1;
      end
      if (mode == 2 && cyc == 4) begin
        start = 1'b1;
        base  = 8'h30;
        len   = 9'd2;
      end else begin
        start = 1'b0;
      end
      #1;
      if (cyc == 1) chk("busy_c1", int'(busy), 1);
      if (prev_stall) begin
        chk("hold_valid", int'(valid), 1);
        chk("hold_data", int'(data), int'(prev_data));
      end
      popnow = valid & ready;
      if (valid && first_v < 0) first_v = cyc;
      if (rom_rd_en) begin
        ea = b + 8'(n_iss);
        chk("rom_addr", int'(rom_addr), int'(ea));
        chk("credit", int'((n_iss - n_pop - int'(popnow)) <= 1), 1);
        n_iss++;
      end
      if (popnow) begin
        ea = b + 8'(n_pop);
        chk("word", int'(data), int'(rom_f(ea)));
        chk("last", int'(last), int'(n_pop == int'(n) - 1));
        n_pop++;
      end
      prev_stall = valid & ~ready;
      prev_data  = data;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    if (done_cyc < 0) chk("timeout", 0, 1);
    chk("issued", n_iss, int'(n));
    chk("popped", n_pop, int'(n));
    if (exp_done >= 0) begin
      chk("done_cycle", done_cyc, exp_done);
      chk("first_valid", first_v, (n == 0) ? -1 : 3);
    end
    start = 1'b0;
    @(negedge clk);
    #1;
    chk("done_one_cycle", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    base  = 8'h00;
    len   = 9'd0;
    ready = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_en", int'(rom_rd_en), 0);
    chk("rst_addr", int'(rom_addr), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_data", int'(data), 0);
    chk("rst_last", int'(last), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    xfer(8'h04, 9'd5, 0, 8);
    xfer(8'h00, 9'd8, 1, -1);
    xfer(8'h00, 9'd0, 0, 1);
    xfer(8'hFE, 9'd4, 0, 7);
    xfer(8'h10, 9'd6, 2, 9);

    start = 1'b1;
    base  = 8'h00;
    len   = 9'd8;
    ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("pre_rst_valid", int'(valid), 1);
    chk("pre_rst_data", int'(data), 8'h12);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_valid", int'(valid), 0);
    chk("mid_rst_data", int'(data), 0);
    chk("mid_rst_rd_en", int'(rom_rd_en), 0);
    chk("mid_rst_addr", int'(rom_addr), 0);
    chk("mid_rst_last", int'(last), 0);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("mid_rst_done", int'(done), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_busy", int'(busy), 0);
    xfer(8'h08, 9'd3, 0, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
